// File: rtl/lc3_mmio_bridge_if.sv
// Bundle of the CPU bus, RAM port, keyboard source and display sink for the LC-3 MMIO bridge.
// Purely combinational wiring, so it adds no latency of its own.
// Flow control is carried by kb_valid/kb_ready and dd_valid/dd_ready.
interface lc3_mmio_bridge_if;
  // CPU side
  logic [15:0] addr;
  logic [15:0] dataWrite;
  logic        dataWrEn;
  logic        rdEn;
  logic [15:0] dataRead;
  // RAM side
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  // Keyboard source
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  // Display sink
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready;

  // The environment side: CPU, RAM model, keyboard and display
  modport master (
    output addr, dataWrite, dataWrEn, rdEn, mem_rdata, kb_valid, kb_data, dd_ready,
    input  dataRead, mem_addr, mem_wdata, mem_we, kb_ready, dd_valid, dd_data
  );

  // The bridge side
  modport slave (
    input  addr, dataWrite, dataWrEn, rdEn, mem_rdata, kb_valid, kb_data, dd_ready,
    output dataRead, mem_addr, mem_wdata, mem_we, kb_ready, dd_valid, dd_data
  );
endinterface

// File: rtl/lc3_mmio_bridge.sv
// LC-3 memory-mapped I/O bridge: decodes KBSR/KBDR/DSR/DDR, passes all other addresses to RAM.
// Latency: reads and RAM strobes are combinational; a keyboard byte or display push is visible after one edge.
// Backpressure: kb_ready drops while a keyboard byte is held; display writes to a full FIFO are dropped and flagged as overflow.
module lc3_mmio_bridge #(
  parameter int          DD_DEPTH  = 4,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00
) (
  input logic              clk,
  input logic              rst,
  lc3_mmio_bridge_if.slave bus
);

  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam int          PW        = (DD_DEPTH > 2) ? $clog2(DD_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C   = (PW + 1)'(DD_DEPTH);

  // Keyboard holding register
  logic       kb_full_q, kb_full_d;
  logic [7:0] kb_byte_q, kb_byte_d;

  // Display FIFO: circular buffer, pointers wrap naturally because depth is a power of two
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    fifo_q [DD_DEPTH];
  logic [7:0]    fifo_d [DD_DEPTH];

  // Sticky display overflow flag
  logic ovf_q, ovf_d;

  logic io_hit;
  logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
  logic dd_full, dd_empty;
  logic push, pop, ddr_wr;

  // Address decode and FIFO status from registered state only
  always_comb begin
    hit_kbsr = (bus.addr == KBSR_ADDR);
    hit_kbdr = (bus.addr == KBDR_ADDR);
    hit_dsr  = (bus.addr == DSR_ADDR);
    hit_ddr  = (bus.addr == DDR_ADDR);
    io_hit   = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;
    dd_full  = (count_q == DEPTH_C);
    dd_empty = (count_q == '0);
    ddr_wr   = bus.dataWrEn & hit_ddr;
    push     = ddr_wr & ~dd_full;
    pop      = ~dd_empty & bus.dd_ready;
  end

  // RAM pass-through, handshake outputs and CPU read mux
  always_comb begin
    bus.mem_addr  = bus.addr;
    bus.mem_wdata = bus.dataWrite;
    bus.mem_we    = bus.dataWrEn & ~io_hit;
    bus.kb_ready  = ~kb_full_q;
    bus.dd_valid  = ~dd_empty;
    bus.dd_data   = dd_empty ? 8'h00 : fifo_q[rd_ptr_q];
    if (hit_kbsr)      bus.dataRead = {kb_full_q, 15'b0};
    else if (hit_kbdr) bus.dataRead = {8'h00, kb_byte_q};
    else if (hit_dsr)  bus.dataRead = {~dd_full, 14'b0, ovf_q};
    else if (hit_ddr)  bus.dataRead = 16'h0000;
    else               bus.dataRead = bus.mem_rdata;
  end

  // Next-state: keyboard capture/consume, FIFO push/pop, overflow set/clear
  always_comb begin
    kb_full_d = kb_full_q;
    kb_byte_d = kb_byte_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    fifo_d    = fifo_q;
    ovf_d     = ovf_q;

    // Consume only matters when full; capture only happens when empty, so they never collide
    if (bus.rdEn && hit_kbdr) kb_full_d = 1'b0;
    if (bus.kb_valid && !kb_full_q) begin
      kb_byte_d = bus.kb_data;
      kb_full_d = 1'b1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = bus.dataWrite[7:0];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Overflow is judged against the registered full flag, and beats a same-cycle clear
    if (bus.dataWrEn && hit_dsr && bus.dataWrite[0]) ovf_d = 1'b0;
    if (ddr_wr && dd_full) ovf_d = 1'b1;
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kb_full_q <= 1'b0;
      kb_byte_q <= 8'h00;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      kb_full_q <= kb_full_d;
      kb_byte_q <= kb_byte_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_lc3_mmio_bridge.sv
// Directed bench for lc3_mmio_bridge: RAM pass-through, keyboard, display FIFO, overflow, wrap, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later, well before the next edge.
// The display sink is held off or released explicitly with dd_ready in each step.
module tb_lc3_mmio_bridge;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lc3_mmio_bridge_if bus ();

  lc3_mmio_bridge #(.DD_DEPTH(4), .KBSR_ADDR(16'hFE00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Small RAM model: combinational read, write on the edge
  logic [15:0] ram [256];
  always_ff @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave time for new inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dataWrEn  = 1'b0;
    bus.rdEn      = 1'b0;
    bus.kb_valid  = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr      = a;
    bus.dataWrite = d;
    bus.dataWrEn  = 1'b1;
    tick();
    bus.dataWrEn  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.dataRead, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    rst           = 1'b0;
    bus.addr      = 16'h0000;
    bus.dataWrite = 16'h0000;
    bus.dd_ready  = 1'b0;
    bus.kb_data   = 8'h00;
    idle();

    // Reset state
    #2;
    chk("rst_kb_ready", {15'b0, bus.kb_ready}, 16'h0001);
    chk("rst_dd_valid", {15'b0, bus.dd_valid}, 16'h0000);
    chk("rst_dd_data",  {8'h00, bus.dd_data},  16'h0000);
    rd("rst_kbsr", 16'hFE00, 16'h0000);
    rd("rst_dsr",  16'hFE04, 16'h8000);
    #2 rst = 1'b1;
    tick();

    // RAM pass-through
    bus.addr = 16'h3000; bus.dataWrite = 16'h1234; bus.dataWrEn = 1'b1;
    #1;
    chk("ram_we_wr",   {15'b0, bus.mem_we}, 16'h0001);
    chk("ram_addr",    bus.mem_addr,        16'h3000);
    chk("ram_wdata",   bus.mem_wdata,       16'h1234);
    tick();
    bus.dataWrEn = 1'b0;
    #1;
    chk("ram_we_idle", {15'b0, bus.mem_we}, 16'h0000);
    chk("ram_rdback",  bus.dataRead,        16'h1234);

    // Write to DDR never reaches RAM; the byte lands in the FIFO one edge later
    bus.addr = 16'hFE06; bus.dataWrite = 16'h005A; bus.dataWrEn = 1'b1;
    #1;
    chk("ddr_no_ram_we", {15'b0, bus.mem_we}, 16'h0000);
    chk("ddr_pre_valid", {15'b0, bus.dd_valid}, 16'h0000);
    tick();
    bus.dataWrEn = 1'b0;
    #1;
    chk("push_lat_valid", {15'b0, bus.dd_valid}, 16'h0001);
    chk("push_lat_data",  {8'h00, bus.dd_data},  16'h005A);
    rd("ddr_reads_zero", 16'hFE06, 16'h0000);
    bus.dd_ready = 1'b1;
    tick();
    bus.dd_ready = 1'b0;
    chk("pop_empty", {15'b0, bus.dd_valid}, 16'h0000);

    // Writes to keyboard registers are ignored and do not hit RAM
    bus.addr = 16'hFE00; bus.dataWrite = 16'hFFFF; bus.dataWrEn = 1'b1;
    #1;
    chk("kbsr_no_ram_we", {15'b0, bus.mem_we}, 16'h0000);
    tick();
    idle();
    rd("kbsr_wr_ignored", 16'hFE00, 16'h0000);

    // Keyboard capture, hold-off while full, consume
    bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
    tick();
    bus.kb_data = 8'h42;
    #1;
    chk("kb_ready_full", {15'b0, bus.kb_ready}, 16'h0000);
    tick();
    bus.kb_valid = 1'b0;
    rd("kbsr_full", 16'hFE00, 16'h8000);
    rd("kbdr_byte", 16'hFE02, 16'h0041);
    bus.rdEn = 1'b1; bus.addr = 16'hFE00;
    tick();
    bus.rdEn = 1'b0;
    rd("rden_other_noeff", 16'hFE00, 16'h8000);
    bus.addr = 16'hFE02; bus.rdEn = 1'b1;
    tick();
    bus.rdEn = 1'b0;
    rd("kbsr_consumed", 16'hFE00, 16'h0000);
    chk("kb_ready_again", {15'b0, bus.kb_ready}, 16'h0001);
    rd("kbdr_retained", 16'hFE02, 16'h0041);

    // Display FIFO fill, overflow, drain in order
    bus.dd_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'hFE06, 16'h0061 + 16'(i));
    rd("dsr_full", 16'hFE04, 16'h0000);
    wr(16'hFE06, 16'h0065);
    rd("dsr_ovf", 16'hFE04, 16'h0001);
    bus.dd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data", {8'h00, bus.dd_data}, 16'h0061 + 16'(i));
      tick();
    end
    chk("drain_empty", {15'b0, bus.dd_valid}, 16'h0000);
    chk("drain_empty_data", {8'h00, bus.dd_data}, 16'h0000);

    // Clearing ovf needs bit 0 set
    wr(16'hFE04, 16'h0000);
    rd("dsr_clr_bit0_zero", 16'hFE04, 16'h8001);
    wr(16'hFE04, 16'h0001);
    rd("dsr_cleared", 16'hFE04, 16'h8000);

    // Full FIFO with pop and push in the same cycle: push dropped, overflow set
    bus.dd_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'hFE06, 16'h0071 + 16'(i));
    bus.dd_ready = 1'b1;
    wr(16'hFE06, 16'h0075);
    rd("full_pushpop_dsr", 16'hFE04, 16'h8001);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_pushpop_data", {8'h00, bus.dd_data}, 16'h0072 + 16'(i));
      tick();
    end
    chk("full_pushpop_dropped", {15'b0, bus.dd_valid}, 16'h0000);
    wr(16'hFE04, 16'h0001);
    rd("ovf_clear2", 16'hFE04, 16'h8000);

    // Ten back-to-back push/pop pairs wrap the pointers and keep order
    bus.dd_ready = 1'b1;
    bus.addr = 16'hFE06;
    bus.dataWrEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.dataWrite = 16'h0080 + 16'(i);
      tick();
      chk("wrap_data", {8'h00, bus.dd_data}, 16'h0080 + 16'(i));
    end
    bus.dataWrEn = 1'b0;
    tick();
    chk("wrap_empty", {15'b0, bus.dd_valid}, 16'h0000);
    rd("wrap_no_ovf", 16'hFE04, 16'h8000);

    // Async reset between edges with 3 bytes queued and a keyboard byte held
    bus.dd_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(16'hFE06, 16'h0090 + 16'(i));
    bus.kb_valid = 1'b1; bus.kb_data = 8'h55;
    tick();
    bus.kb_valid = 1'b0;
    chk("pre_rst_valid", {15'b0, bus.dd_valid}, 16'h0001);
    chk("pre_rst_kb",    {15'b0, bus.kb_ready}, 16'h0000);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_valid", {15'b0, bus.dd_valid}, 16'h0000);
    chk("async_rst_kb",    {15'b0, bus.kb_ready}, 16'h0001);
    rd("async_rst_kbdr", 16'hFE02, 16'h0000);
    rd("async_rst_dsr",  16'hFE04, 16'h8000);
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {15'b0, bus.dd_valid}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
